// File: rtl/enemy_motion5.sv
// Falling enemy sprite: spawns in an LFSR-chosen lane, steps down on each tick edge,
// freezes on hit, waits to respawn. Optional ENEMY_SPEEDUP_EN raises the step after each exit.
module enemy_motion5 #(
  parameter int unsigned STEP          = 4,
  parameter int unsigned Y_START       = 0,
  parameter int unsigned Y_END         = 480,
  parameter int unsigned LANE_X0       = 200,
  parameter int unsigned LANE_PITCH    = 80,
  parameter int unsigned RESPAWN_TICKS = 8,
  parameter int unsigned HIT_TICKS     = 4
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_in,
  input  logic       hit,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] lane,
  output logic       active,
  output logic       passed
);

  typedef enum logic [1:0] {IDLE, MOVE, HIT, WAIT} state_t;

  state_t      state_q, state_d;
  logic        t1_q, t1_d, t2_q, t2_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  lane_q, lane_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [10:0] pos_y_q, pos_y_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic        passed_q, passed_d;
  logic [10:0] step_w;
  logic [10:0] next_y;
  logic        spawn;
`ifdef ENEMY_SPEEDUP_EN
  logic [3:0]  step_q, step_d;
`endif

  always_comb begin
    t1_d     = tick_in;
    t2_d     = t1_q;
    strobe_d = t1_q & ~t2_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef ENEMY_SPEEDUP_EN
    step_w = {7'd0, step_q};
    step_d = step_q;
`else
    step_w = 11'(STEP);
`endif
    next_y   = pos_y_q + step_w;
    state_d  = state_q;
    lane_d   = lane_q;
    pos_y_d  = pos_y_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    passed_d = 1'b0;
    spawn    = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      active_d = 1'b0;
      pos_y_d  = 11'(Y_START);
`ifdef ENEMY_SPEEDUP_EN
      step_d   = 4'(STEP);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          spawn = 1'b1;
`ifdef ENEMY_SPEEDUP_EN
          step_d = 4'(STEP);
`endif
        end
        MOVE: begin
          // hit outranks a coincident step strobe; the exit pulse is suppressed
          if (hit) begin
            state_d = HIT;
            cnt_d   = '0;
          end else if (strobe_q) begin
            if (next_y >= 11'(Y_END)) begin
              pos_y_d  = 11'(Y_END);
              passed_d = 1'b1;
              active_d = 1'b0;
              state_d  = WAIT;
              cnt_d    = '0;
`ifdef ENEMY_SPEEDUP_EN
              if (step_q < 4'd8) step_d = step_q + 4'd1;
`endif
            end else begin
              pos_y_d = next_y;
            end
          end
        end
        HIT: begin
          if (strobe_q) begin
            if (cnt_q == 4'(HIT_TICKS - 1)) begin
              state_d  = WAIT;
              cnt_d    = '0;
              active_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        WAIT: begin
          if (strobe_q) begin
            if (cnt_q == 4'(RESPAWN_TICKS - 1)) spawn = 1'b1;
            else cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (spawn) begin
      lane_d   = lfsr_q[1:0];
      pos_y_d  = 11'(Y_START);
      active_d = 1'b1;
      state_d  = MOVE;
      cnt_d    = '0;
    end

    pos_x_d = 10'(LANE_X0 + LANE_PITCH * 32'(lane_d));
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q  <= IDLE;
      t1_q     <= 1'b0;
      t2_q     <= 1'b0;
      strobe_q <= 1'b0;
      lfsr_q   <= 8'hA5;
      lane_q   <= '0;
      pos_x_q  <= 10'(LANE_X0);
      pos_y_q  <= 11'(Y_START);
      cnt_q    <= '0;
      active_q <= 1'b0;
      passed_q <= 1'b0;
`ifdef ENEMY_SPEEDUP_EN
      step_q   <= 4'(STEP);
`endif
    end else begin
      state_q  <= state_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      strobe_q <= strobe_d;
      lfsr_q   <= lfsr_d;
      lane_q   <= lane_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      passed_q <= passed_d;
`ifdef ENEMY_SPEEDUP_EN
      step_q   <= step_d;
`endif
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q[9:0];
  assign lane   = lane_q;
  assign active = active_q;
  assign passed = passed_q;

endmodule

// File: tb/tb_enemy_motion5.sv
// Self-checking bench for enemy_motion5: tick-history behavioural model plus directed
// literal checks. Build with ENEMY_SPEEDUP_EN defined to exercise the speed-up variant.
module tb_enemy_motion5;

  logic       clk = 1'b0;
  logic       reset, enable, tick_in, hit;
  logic [9:0] pos_x, pos_y;
  logic [1:0] lane;
  logic       active, passed;

  int checks = 0;
  int errors = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  enemy_motion5 #(
    .STEP(4), .Y_START(0), .Y_END(480), .LANE_X0(200), .LANE_PITCH(80),
    .RESPAWN_TICKS(8), .HIT_TICKS(4)
  ) dut (
    .clock_in(clk), .reset(reset), .enable(enable), .tick_in(tick_in), .hit(hit),
    .pos_x(pos_x), .pos_y(pos_y), .lane(lane), .active(active), .passed(passed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases with countdowns, strobe derived from tick_in sample history
  localparam int PH_IDLE = 0, PH_FALL = 1, PH_FROZEN = 2, PH_RESPAWN = 3;
  int         m_y, m_lane, m_active, m_passed, m_phase, m_left, m_step;
  bit         h1, h2, h3, m_strobe, started;
  logic [7:0] m_lfsr, m_lnow;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    // taps 8,6,5,4 in 1-based numbering
    return {v[6:0], v[8-1] ^ v[6-1] ^ v[5-1] ^ v[4-1]};
  endfunction

  task automatic m_spawn(input logic [7:0] l);
    m_lane   = int'(l[1:0]);
    m_y      = 0;
    m_active = 1;
    m_phase  = PH_FALL;
  endtask

  always @(posedge clk) begin
    m_strobe = h2 && !h3;
    if (reset) begin
      started = 1'b1;
      m_y = 0; m_lane = 0; m_active = 0; m_passed = 0; m_phase = PH_IDLE;
      m_left = 0; m_step = 4; m_lfsr = 8'hA5;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      m_lnow = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      m_passed = 0;
      if (!enable) begin
        m_phase = PH_IDLE; m_y = 0; m_active = 0; m_step = 4;
      end else begin
        case (m_phase)
          PH_IDLE: m_spawn(m_lnow);
          PH_FALL: begin
            if (hit) begin
              m_phase = PH_FROZEN; m_left = 4;
            end else if (m_strobe) begin
              if (m_y + m_step >= 480) begin
                m_y = 480; m_passed = 1; m_active = 0; m_phase = PH_RESPAWN; m_left = 8;
`ifdef ENEMY_SPEEDUP_EN
                if (m_step < 8) m_step++;
`endif
              end else begin
                m_y += m_step;
              end
            end
          end
          PH_FROZEN: if (m_strobe) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = PH_RESPAWN; m_left = 8; m_active = 0;
            end
          end
          default: if (m_strobe) begin
            m_left--;
            if (m_left == 0) m_spawn(m_lnow);
          end
        endcase
      end
      h3 = h2; h2 = h1; h1 = tick_in;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("pos_y", 32'(pos_y), 32'(m_y));
      chk("pos_x", 32'(pos_x), 32'(200 + 80 * m_lane));
      chk("lane", 32'(lane), 32'(m_lane));
      chk("active", 32'(active), 32'(m_active));
      chk("passed", 32'(passed), 32'(m_passed));
    end
    if (passed === 1'b1) pass_cnt++;
  end

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    settle();
    tick_in = 1'b0;
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, d, n;
    int exp_step[6];
`ifdef ENEMY_SPEEDUP_EN
    exp_step = '{4, 5, 6, 7, 8, 8};
`else
    exp_step = '{4, 4, 4, 4, 4, 4};
`endif
    reset = 1'b1; enable = 1'b0; tick_in = 1'b0; hit = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pos_y", 32'(pos_y), 0);
    chk("rst_pos_x", 32'(pos_x), 200);
    chk("rst_lane", 32'(lane), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_passed", 32'(passed), 0);

    // spawn on first enabled edge: seed A5 gives lane 1
    reset = 1'b0; enable = 1'b1;
    settle();
    chk("spawn_active", 32'(active), 1);
    chk("spawn_pos_y", 32'(pos_y), 0);
    chk("spawn_lane", 32'(lane), 1);
    chk("spawn_pos_x", 32'(pos_x), 280);

    // full descent
    p0 = pass_cnt;
    repeat (119) tick();
    settle();
    chk("fall_476", 32'(pos_y), 476);
    tick();
    settle();
    chk("exit_pos_y", 32'(pos_y), 480);
    chk("exit_passed", 32'(passed), 1);
    settle();
    chk("exit_active", 32'(active), 0);
    chk("exit_pulse_count", 32'(pass_cnt - p0), 1);
    chk("exit_passed_low", 32'(passed), 0);

    repeat (7) tick();
    settle();
    chk("wait_7_active", 32'(active), 0);
    tick();
    settle();
    chk("respawn_active", 32'(active), 1);
    chk("respawn_pos_y", 32'(pos_y), 0);

    // long tick_in high: a single step two edges after first sample
    tick_in = 1'b1;
    settle();
    chk("hold_e0", 32'(pos_y), 0);
    settle();
    chk("hold_e1", 32'(pos_y), 0);
    settle();
    chk("hold_e2", 32'(pos_y), 4);
    repeat (47) settle();
    chk("hold_end", 32'(pos_y), 4);
    tick_in = 1'b0;
    repeat (3) settle();
    chk("hold_after", 32'(pos_y), 4);

    // hit coinciding with a step strobe at y=100
    repeat (24) tick();
    settle();
    chk("pre_hit_y", 32'(pos_y), 100);
    tick_in = 1'b1;
    settle();
    tick_in = 1'b0;
    settle();
    hit = 1'b1;
    settle();
    chk("hit_pos_y", 32'(pos_y), 100);
    chk("hit_active", 32'(active), 1);
    repeat (3) tick();
    settle();
    chk("hit_3_active", 32'(active), 1);
    chk("hit_frozen_y", 32'(pos_y), 100);
    tick();
    hit = 1'b0;
    settle();
    chk("hit_done_active", 32'(active), 0);
    repeat (8) tick();
    settle();
    chk("hit_respawn_active", 32'(active), 1);
    chk("hit_respawn_y", 32'(pos_y), 0);

    // enable drop while frozen
    repeat (5) tick();
    hit = 1'b1;
    settle();
    hit = 1'b0;
    settle();
    chk("hit2_active", 32'(active), 1);
    p0 = pass_cnt;
    enable = 1'b0;
    settle();
    chk("dis_pos_y", 32'(pos_y), 0);
    chk("dis_active", 32'(active), 0);
    enable = 1'b1;
    settle();
    chk("reen_active", 32'(active), 1);

    // reset mid-fall at y=240
    repeat (60) tick();
    settle();
    chk("pre_rst_y", 32'(pos_y), 240);
    reset = 1'b1; tick_in = 1'b1;
    settle();
    chk("mid_rst_y", 32'(pos_y), 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_pos_x", 32'(pos_x), 200);
    reset = 1'b0; tick_in = 1'b0;
    repeat (2) settle();
    chk("no_pass_pulse", 32'(pass_cnt - p0), 0);

    // consecutive exits: first step after each spawn
    for (int e = 0; e < 6; e++) begin
      n = 0;
      while (active !== 1'b1 && n < 40) begin tick(); settle(); n++; end
      chk("respawn_bound", 32'(n < 40), 1);
      tick();
      settle();
      d = int'(pos_y);
      chk($sformatf("step_exit%0d", e), 32'(d), 32'(exp_step[e]));
      p0 = pass_cnt;
      n = 0;
      while (active === 1'b1 && n < 200) begin tick(); settle(); n++; end
      chk("exit_bound", 32'(n < 200), 1);
      settle();
      chk($sformatf("pulse_exit%0d", e), 32'(pass_cnt - p0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_motion5.md
ENEMY_MOTION5 -- requirements
Module: enemy_motion5

Interface
REQ-001 The block SHALL have these parameters:
- STEP, 4, pixels moved per tick.
- Y_START, 0, spawn row.
- Y_END, 480, exit row.
- LANE_X0, 200, x of lane 0.
- LANE_PITCH, 80, x spacing between lanes.
- RESPAWN_TICKS, 8, ticks between exit and next spawn.
- HIT_TICKS, 4, ticks frozen after a hit.
REQ-002 The block SHALL have these ports:
- clock_in, in, 1, system clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, game running.
- tick_in, in, 1, enemy-speed square wave from the enemy clock divider.
- hit, in, 1, collision with player, level-sampled.
- pos_x, out, 10, enemy x.
- pos_y, out, 10, enemy y.
- lane, out, 2, current lane.
- active, out, 1, enemy drawable.
- passed, out, 1, one-cycle pulse when the enemy exits the bottom row.

Function
REQ-003 tick_in SHALL pass through two registers (t1, t2); the step strobe is t1 & ~t2.
REQ-004 Latency: if tick_in is first sampled high at edge E0, the step strobe SHALL be high after E1 and pos_y SHALL update at E2.
REQ-005 A tick_in high level of any length SHALL produce exactly one step strobe.
REQ-006 An 8-bit LFSR (seed 8'hA5, taps 8,6,5,4) SHALL advance every cycle; lane SHALL latch lfsr[1:0] only at spawn.
REQ-007 pos_x SHALL equal LANE_X0 + lane*LANE_PITCH, registered alongside lane.
REQ-008 The FSM SHALL have states IDLE, MOVE, HIT and WAIT.
REQ-009 IDLE: active=0, pos_y=Y_START; when enable=1, spawn (latch lane, pos_y=Y_START) and go to MOVE next cycle.
REQ-010 MOVE, on a step strobe: if pos_y+STEP >= Y_END, pos_y SHALL become Y_END, passed SHALL pulse 1 cycle, active SHALL go 0, and the FSM SHALL go to WAIT; otherwise pos_y SHALL become pos_y+STEP.
REQ-011 MOVE with hit=1 SHALL go to HIT, with pos_y held; hit SHALL take priority over a same-cycle step strobe, and passed SHALL NOT pulse.
REQ-012 HIT: active=1 and position frozen; after HIT_TICKS step strobes, the FSM SHALL go to WAIT with active=0; hit SHALL be ignored in HIT.
REQ-013 WAIT: active=0; after RESPAWN_TICKS step strobes, the block SHALL spawn and go to MOVE.
REQ-014 Tick counters SHALL be 4 bits, cleared on every state entry.
REQ-015 enable=0 in any state SHALL force IDLE on the next edge, clear the counters, set active=0 and set pos_y=Y_START; this SHALL have priority over hit and step.
REQ-016 pos_y arithmetic SHALL be 11-bit internally so that pos_y+STEP cannot wrap; pos_y SHALL never exceed Y_END.
REQ-017 passed SHALL be the only pulse output and SHALL never be high for two consecutive cycles.

Reset
REQ-018 reset SHALL have priority over all inputs.
REQ-019 On reset the block SHALL enter IDLE with: pos_y=Y_START, lane=0, pos_x=LANE_X0, active=0, passed=0, t1=t2=0, counters=0, lfsr=8'hA5.
REQ-020 reset asserted mid-MOVE or mid-HIT SHALL take effect at the same edge; the block SHALL emit no passed pulse.

Configuration
REQ-021 With ENEMY_SPEEDUP_EN defined:
- An effective step register (4 bits, reset to STEP) SHALL increment by 1 on each passed pulse, saturating at 8.
- Every pos_y update in MOVE SHALL use the effective step.
- The effective step SHALL reset to STEP on reset or in IDLE.
REQ-022 Without ENEMY_SPEEDUP_EN, the step SHALL be the constant STEP and no speed register SHALL exist.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then enable=1 -> active=1 one cycle later; pos_y=0; pos_x=200+80*lane with lane=8'hA5-derived LFSR[1:0] at spawn.
- 120 tick pulses in MOVE, no hit -> pos_y steps 0,4,...,476, then 480; passed high exactly 1 cycle; active=0.
- tick_in held high 50 cycles -> exactly one 4-pixel step, 2 edges after first sample.
- hit and step strobe in the same cycle at pos_y=100 -> HIT entered, pos_y stays 100; after 4 ticks active=0; after 8 more ticks a respawn at pos_y=0.
- enable=0 during HIT, and separately reset at pos_y=240 -> IDLE next edge, pos_y=0, active=0, no passed pulse.
- ENEMY_SPEEDUP_EN defined, 5 consecutive exits -> step sizes 4,5,6,7,8 with saturation at 8 on the 6th pass; macro undefined -> step always 4.
